// File: rtl/uart_bus_bridge.sv
// UART-to-bus initiator: 8N1 receiver and transmitter plus a framing FSM that
// turns 'W'/'R' command frames into single-cycle bus writes and reads.
module uart_bus_bridge #(
    parameter int CLK_FREQUENCY = 50,
    parameter int BAUD_RATE     = 115200,
    parameter int READ_LATENCY  = 1,
    parameter int TIMEOUT_BITS  = 40
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        write_valid,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic        read_valid,
    output logic [31:0] read_address,
    input  logic [31:0] read_data,
    output logic        busy,
    output logic [2:0]  o_dbg_state
);
    localparam int CPB     = (CLK_FREQUENCY * 1000000) / BAUD_RATE;
    localparam int HALF    = CPB / 2;
    localparam int TIMEOUT = TIMEOUT_BITS * CPB;
    localparam int CW      = $clog2(CPB + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);

    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_READ      = 3'd4;
    localparam logic [2:0] S_READ_WAIT = 3'd5;
    localparam logic [2:0] S_RESP      = 3'd6;

    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    logic [1:0]    r_rx_state;
    logic [CW-1:0] r_rx_cyc;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_byte;
    logic          r_rx_strobe;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_cyc    <= '0;
            r_rx_bit    <= '0;
            r_rx_byte   <= '0;
            r_rx_strobe <= 1'b0;
        end else begin
            r_rx_s1     <= rx_pin;
            r_rx_s2     <= r_rx_s1;
            r_rx_prev   <= r_rx_s2;
            r_rx_strobe <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_state <= RX_START;
                        r_rx_cyc   <= '0;
                    end
                end
                RX_START: begin
                    // A line that is high again at mid-start was a glitch.
                    if (r_rx_cyc == CW'(HALF - 1)) begin
                        r_rx_cyc   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cyc <= r_rx_cyc + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cyc == CW'(CPB - 1)) begin
                        r_rx_cyc  <= '0;
                        r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
                        r_rx_bit  <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cyc <= r_rx_cyc + CW'(1);
                    end
                end
                default: begin
                    if (r_rx_cyc == CW'(CPB - 1)) begin
                        r_rx_cyc    <= '0;
                        r_rx_strobe <= r_rx_s2;
                        r_rx_state  <= RX_IDLE;
                    end else begin
                        r_rx_cyc <= r_rx_cyc + CW'(1);
                    end
                end
            endcase
        end
    end

    logic          r_tx_busy, r_tx_pin;
    logic [8:0]    r_tx_sh;
    logic [3:0]    r_tx_bit;
    logic [CW-1:0] r_tx_cyc;
    logic          w_tx_ready, w_tx_load;
    logic [7:0]    w_tx_byte;

    // Ready already in the final stop-bit cycle so queued bytes follow with no gap.
    assign w_tx_ready = !r_tx_busy || (r_tx_bit == 4'd9 && r_tx_cyc == CW'(CPB - 1));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_tx_busy <= 1'b0;
            r_tx_pin  <= 1'b1;
            r_tx_sh   <= '1;
            r_tx_bit  <= '0;
            r_tx_cyc  <= '0;
        end else if (w_tx_load) begin
            r_tx_busy <= 1'b1;
            r_tx_pin  <= 1'b0;
            r_tx_sh   <= {1'b1, w_tx_byte};
            r_tx_bit  <= '0;
            r_tx_cyc  <= '0;
        end else if (r_tx_busy) begin
            if (r_tx_cyc == CW'(CPB - 1)) begin
                r_tx_cyc <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx_pin  <= 1'b1;
                end else begin
                    r_tx_pin <= r_tx_sh[0];
                    r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
                    r_tx_bit <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cyc <= r_tx_cyc + CW'(1);
            end
        end
    end

    logic [2:0]    r_state;
    logic [1:0]    r_cnt;
    logic          r_is_write;
    logic [31:0]   r_addr_sh, r_data_sh;
    logic [31:0]   r_wr_addr, r_wr_data, r_rd_addr;
    logic          r_wv, r_rv;
    logic [TW-1:0] r_to;
    logic [2:0]    r_lat;
    logic [31:0]   r_resp;
    logic [2:0]    r_left;

    assign w_tx_load = (r_state == S_RESP) && (r_left != 3'd0) && w_tx_ready;
    assign w_tx_byte = r_resp[31:24];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_addr_sh  <= '0;
            r_data_sh  <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_rd_addr  <= '0;
            r_wv       <= 1'b0;
            r_rv       <= 1'b0;
            r_to       <= '0;
            r_lat      <= '0;
            r_resp     <= '0;
            r_left     <= '0;
        end else begin
            r_wv <= 1'b0;
            r_rv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_rx_strobe) begin
                        r_cnt <= '0;
                        r_to  <= '0;
                        if (r_rx_byte == 8'h57 || r_rx_byte == 8'h52) begin
                            r_is_write <= (r_rx_byte == 8'h57);
                            r_state    <= S_ADDR;
                        end else begin
                            r_resp  <= {8'h15, 24'h0};
                            r_left  <= 3'd1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (r_rx_strobe) begin
                        r_to      <= '0;
                        r_cnt     <= r_cnt + 2'd1;
                        r_addr_sh <= {r_addr_sh[23:0], r_rx_byte};
                        if (r_cnt == 2'd3) begin
                            if (r_is_write) begin
                                r_state <= S_DATA;
                            end else begin
                                r_rv      <= 1'b1;
                                r_rd_addr <= {r_addr_sh[23:0], r_rx_byte};
                                r_state   <= S_READ;
                            end
                        end
                    end else if (r_to == TW'(TIMEOUT - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_to <= r_to + TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_rx_strobe) begin
                        r_to      <= '0;
                        r_cnt     <= r_cnt + 2'd1;
                        r_data_sh <= {r_data_sh[23:0], r_rx_byte};
                        if (r_cnt == 2'd3) begin
                            r_wv      <= 1'b1;
                            r_wr_addr <= r_addr_sh;
                            r_wr_data <= {r_data_sh[23:0], r_rx_byte};
                            r_state   <= S_WRITE;
                        end
                    end else if (r_to == TW'(TIMEOUT - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_to <= r_to + TW'(1);
                    end
                end
                S_WRITE: begin
                    r_resp  <= {8'h06, 24'h0};
                    r_left  <= 3'd1;
                    r_state <= S_RESP;
                end
                S_READ: begin
                    r_lat   <= 3'd1;
                    r_state <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    // r_lat counts cycles since the read_valid cycle.
                    if (r_lat == 3'(READ_LATENCY)) begin
                        r_resp  <= read_data;
                        r_left  <= 3'd4;
                        r_state <= S_RESP;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                S_RESP: begin
                    if (w_tx_load) begin
                        r_resp <= {r_resp[23:0], 8'h00};
                        r_left <= r_left - 3'd1;
                    end else if (r_left == 3'd0 && !r_tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_pin        = r_tx_pin;
    assign write_valid   = r_wv;
    assign write_address = r_wr_addr;
    assign write_data    = r_wr_data;
    assign read_valid    = r_rv;
    assign read_address  = r_rd_addr;
    assign busy          = (r_state != S_IDLE);
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: two instances (read latency 1 and 3) driven by
// serial frames; tx and bus monitors pop expected items from queues.
module tb_uart_bus_bridge;
    localparam int CPB = 16;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        rx0, rx1;
    logic        tx0, tx1, wv0, wv1, rv0, rv1, busy0, busy1;
    logic [31:0] wa0, wa1, wd0, wd1, ra0, ra1, rd0, rd1;
    logic [2:0]  st0, st1;
    logic [31:0] rd_val0, rd_val1;
    logic [3:0]  sr0 = '0;
    logic [3:0]  sr1 = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          tx_cnt0 = 0;
    int          tx_cnt1 = 0;

    logic [8:0]  exp_tx0[$];
    logic [8:0]  exp_tx1[$];
    logic [64:0] exp_bus0[$];
    logic [64:0] exp_bus1[$];

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    uart_bus_bridge #(.CLK_FREQUENCY(1), .BAUD_RATE(62500), .READ_LATENCY(1), .TIMEOUT_BITS(40)) u_dut0 (
        .clk_in(clk_in), .rst(rst), .rx_pin(rx0), .tx_pin(tx0),
        .write_valid(wv0), .write_address(wa0), .write_data(wd0),
        .read_valid(rv0), .read_address(ra0), .read_data(rd0),
        .busy(busy0), .o_dbg_state(st0)
    );

    uart_bus_bridge #(.CLK_FREQUENCY(1), .BAUD_RATE(62500), .READ_LATENCY(3), .TIMEOUT_BITS(40)) u_dut1 (
        .clk_in(clk_in), .rst(rst), .rx_pin(rx1), .tx_pin(tx1),
        .write_valid(wv1), .write_address(wa1), .write_data(wd1),
        .read_valid(rv1), .read_address(ra1), .read_data(rd1),
        .busy(busy1), .o_dbg_state(st1)
    );

    // Bus model: data is only correct in the cycle READ_LATENCY after read_valid.
    always @(posedge clk_in) begin
        sr0 <= {sr0[2:0], rv0};
        sr1 <= {sr1[2:0], rv1};
    end
    assign rd0 = sr0[0] ? rd_val0 : 32'h0BAD0BAD;
    assign rd1 = sr1[2] ? rd_val1 : 32'h0BAD0BAD;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic logic tx_of(input int idx);
        return (idx == 0) ? tx0 : tx1;
    endfunction

    function automatic logic busy_of(input int idx);
        return (idx == 0) ? busy0 : busy1;
    endfunction

    task automatic set_rx(input int idx, input logic v);
        if (idx == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic wait_n(input int n, output logic hit);
        hit = 1'b0;
        repeat (n) begin
            @(negedge clk_in);
            if (rst) hit = 1'b1;
        end
    endtask

    task automatic tx_monitor(input int idx);
        logic prev, cur, hit, ab, stop_bit, empty;
        logic [7:0] b;
        logic [8:0] e;
        int start, last_start;
        prev = 1'b1;
        last_start = -100000;
        b = '0;
        forever begin
            @(negedge clk_in);
            cur = tx_of(idx);
            if (prev === 1'b1 && cur === 1'b0 && !rst) begin
                start = cyc;
                wait_n(CPB / 2, ab);
                for (int i = 0; i < 8; i++) begin
                    wait_n(CPB, hit);
                    ab = ab | hit;
                    b[i] = tx_of(idx);
                end
                wait_n(CPB, hit);
                ab = ab | hit;
                stop_bit = tx_of(idx);
                if (!ab) begin
                    empty = (idx == 0) ? (exp_tx0.size() == 0) : (exp_tx1.size() == 0);
                    total++;
                    if (empty) begin
                        bad++;
                        $display("FAIL tx_unexpected_byte%0d: actual=%0h expected=none", idx, b);
                    end else begin
                        e = (idx == 0) ? exp_tx0.pop_front() : exp_tx1.pop_front();
                        check("tx_byte", {56'd0, b}, {56'd0, e[7:0]});
                        check("tx_stop", {63'd0, stop_bit}, 64'd1);
                        if (e[8]) check("tx_gap", 64'(start - last_start), 64'(10 * CPB));
                    end
                    if (idx == 0) tx_cnt0++;
                    else tx_cnt1++;
                end
                last_start = start;
                cur = tx_of(idx);
            end
            prev = cur;
        end
    endtask

    function automatic void bus_check(input int idx);
        logic w, r, empty;
        logic [31:0] a, d;
        logic [64:0] e;
        w = (idx == 0) ? wv0 : wv1;
        r = (idx == 0) ? rv0 : rv1;
        a = w ? ((idx == 0) ? wa0 : wa1) : ((idx == 0) ? ra0 : ra1);
        d = (idx == 0) ? wd0 : wd1;
        if (w || r) begin
            check("bus_exclusive", {63'd0, w & r}, 64'd0);
            empty = (idx == 0) ? (exp_bus0.size() == 0) : (exp_bus1.size() == 0);
            total++;
            if (empty) begin
                bad++;
                $display("FAIL bus_unexpected_strobe%0d: actual=w%0d r%0d addr=%0h expected=none", idx, w, r, a);
            end else begin
                e = (idx == 0) ? exp_bus0.pop_front() : exp_bus1.pop_front();
                check("bus_kind", {63'd0, w}, {63'd0, e[64]});
                check("bus_addr", {32'd0, a}, {32'd0, e[63:32]});
                if (w) check("bus_wdata", {32'd0, d}, {32'd0, e[31:0]});
            end
        end
    endfunction

    always @(negedge clk_in) begin
        bus_check(0);
        bus_check(1);
    end

    initial tx_monitor(0);
    initial tx_monitor(1);

    task automatic send_byte(input int idx, input logic [7:0] b, input logic stop);
        set_rx(idx, 1'b0);
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            set_rx(idx, b[i]);
            repeat (CPB) @(negedge clk_in);
        end
        set_rx(idx, stop);
        repeat (CPB) @(negedge clk_in);
        set_rx(idx, 1'b1);
    endtask

    task automatic send_frame(input int idx, input logic [71:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_byte(idx, bytes[8 * (n - 1 - i) +: 8], 1'b1);
    endtask

    task automatic wait_idle(input int idx, input int budget, input string name);
        int k;
        k = 0;
        @(negedge clk_in);
        while (busy_of(idx) && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        check(name, {63'd0, busy_of(idx)}, 64'd0);
    endtask

    initial begin
        repeat (200000) @(posedge clk_in);
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, k;
        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rd_val0 = 32'h0;
        rd_val1 = 32'h0;
        repeat (3) @(negedge clk_in);
        check("rst_tx", {63'd0, tx0}, 64'd1);
        check("rst_wv", {63'd0, wv0}, 64'd0);
        check("rst_rv", {63'd0, rv0}, 64'd0);
        check("rst_busy", {63'd0, busy0}, 64'd0);
        check("rst_waddr", {32'd0, wa0}, 64'd0);
        check("rst_wdata", {32'd0, wd0}, 64'd0);
        check("rst_raddr", {32'd0, ra0}, 64'd0);
        check("rst_tx1", {63'd0, tx1}, 64'd1);
        rst = 1'b0;
        repeat (20) @(negedge clk_in);

        // Write frame.
        exp_bus0.push_back({1'b1, 32'h10000000, 32'h41424344});
        exp_tx0.push_back({1'b0, 8'h06});
        send_frame(0, 72'h57_10000000_41424344, 9);
        wait_idle(0, 400, "t1_busy_end");
        check("t1_tx_drained", 64'(exp_tx0.size()), 64'd0);
        check("t1_bus_drained", 64'(exp_bus0.size()), 64'd0);

        // Read frame, latency 1 then latency 3.
        rd_val0 = 32'hDEADBEEF;
        exp_bus0.push_back({1'b0, 32'h10000004, 32'h0});
        exp_tx0.push_back({1'b0, 8'hDE});
        exp_tx0.push_back({1'b1, 8'hAD});
        exp_tx0.push_back({1'b1, 8'hBE});
        exp_tx0.push_back({1'b1, 8'hEF});
        send_frame(0, {32'h0, 40'h52_10000004}, 5);
        wait_idle(0, 1000, "t2_busy_end");
        check("t2_tx_drained", 64'(exp_tx0.size()), 64'd0);

        rd_val1 = 32'hDEADBEEF;
        exp_bus1.push_back({1'b0, 32'h10000004, 32'h0});
        exp_tx1.push_back({1'b0, 8'hDE});
        exp_tx1.push_back({1'b1, 8'hAD});
        exp_tx1.push_back({1'b1, 8'hBE});
        exp_tx1.push_back({1'b1, 8'hEF});
        send_frame(1, {32'h0, 40'h52_10000004}, 5);
        wait_idle(1, 1000, "t2_lat3_busy_end");
        check("t2_lat3_tx_drained", 64'(exp_tx1.size()), 64'd0);

        // Unknown command, then a valid write.
        exp_tx0.push_back({1'b0, 8'h15});
        send_byte(0, 8'h33, 1'b1);
        wait_idle(0, 400, "t3_nak_busy_end");
        check("t3_nak_drained", 64'(exp_tx0.size()), 64'd0);
        exp_bus0.push_back({1'b1, 32'h20000008, 32'h11223344});
        exp_tx0.push_back({1'b0, 8'h06});
        send_frame(0, 72'h57_20000008_11223344, 9);
        wait_idle(0, 400, "t3_write_busy_end");
        check("t3_write_drained", 64'(exp_bus0.size()), 64'd0);

        // Timeout part way through the address.
        send_frame(0, {48'h0, 24'h57_1000}, 3);
        repeat (500) @(negedge clk_in);
        check("t4_busy_before_timeout", {63'd0, busy0}, 64'd1);
        wait_idle(0, 300, "t4_busy_after_timeout");
        rd_val0 = 32'hCAFEF00D;
        exp_bus0.push_back({1'b0, 32'h12345678, 32'h0});
        exp_tx0.push_back({1'b0, 8'hCA});
        exp_tx0.push_back({1'b1, 8'hFE});
        exp_tx0.push_back({1'b1, 8'hF0});
        exp_tx0.push_back({1'b1, 8'h0D});
        send_frame(0, {32'h0, 40'h52_12345678}, 5);
        wait_idle(0, 1000, "t4_read_busy_end");
        check("t4_read_drained", 64'(exp_tx0.size()), 64'd0);

        // Framing error and a short glitch.
        send_byte(0, 8'h57, 1'b0);
        repeat (32) @(negedge clk_in);
        check("t5_frame_err_busy", {63'd0, busy0}, 64'd0);
        check("t5_frame_err_state", {61'd0, st0}, 64'd0);
        rx0 = 1'b0;
        repeat (CPB / 4) @(negedge clk_in);
        rx0 = 1'b1;
        repeat (3 * CPB) @(negedge clk_in);
        check("t5_glitch_busy", {63'd0, busy0}, 64'd0);

        // Reset during the second response byte.
        rd_val0 = 32'h01020304;
        exp_bus0.push_back({1'b0, 32'h40000010, 32'h0});
        exp_tx0.push_back({1'b0, 8'h01});
        n = tx_cnt0;
        send_frame(0, {32'h0, 40'h52_40000010}, 5);
        k = 0;
        while (tx_cnt0 == n && k < 2000) begin
            @(negedge clk_in);
            k++;
        end
        check("t6_first_byte_seen", 64'(tx_cnt0 - n), 64'd1);
        repeat (CPB / 2 + 3 * CPB) @(negedge clk_in);
        check("t6_busy_pre_reset", {63'd0, busy0}, 64'd1);
        rst = 1'b1;
        @(negedge clk_in);
        check("t6_rst_tx", {63'd0, tx0}, 64'd1);
        check("t6_rst_busy", {63'd0, busy0}, 64'd0);
        check("t6_rst_strobes", {62'd0, wv0, rv0}, 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk_in);
        exp_bus0.push_back({1'b1, 32'h3000000C, 32'hA55A0FF0});
        exp_tx0.push_back({1'b0, 8'h06});
        send_frame(0, 72'h57_3000000C_A55A0FF0, 9);
        wait_idle(0, 400, "t6_write_busy_end");

        repeat (20) @(negedge clk_in);
        check("end_tx0_left", 64'(exp_tx0.size()), 64'd0);
        check("end_tx1_left", 64'(exp_tx1.size()), 64'd0);
        check("end_bus0_left", 64'(exp_bus0.size()), 64'd0);
        check("end_bus1_left", 64'(exp_bus1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
